dp_scrambler: RTL and testbench

Two-lane DisplayPort main-link scrambler for the transmit path. It sits directly upstream of the PHY pattern mux and drives its `scrdat0/1` and `scrisk0/1` inputs. It takes framed 16-bit lane words (two 8b symbols per lane per clock), replaces every 512th BS with SR, and XORs data symbols with the DP LFSR sequence. K symbols pass unscrambled.

---
 rtl/dp_scrambler.sv | 141 ++++++++++++++
 tb/tb_dp_scrambler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dp_scrambler.sv
// Two-lane DisplayPort main-link scrambler: BS->SR substitution every 512th BS, LFSR XOR of D symbols.
// Latency: 1 dpclk, registered outputs; K flags delayed in step with data.
// Backpressure: none; accepts one 16-bit word per lane every cycle.
module dp_scrambler (
  input  logic        dpclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] dat0,
  input  logic [15:0] dat1,
  input  logic [1:0]  isk0,
  input  logic [1:0]  isk1,
  output logic [15:0] scrdat0,
  output logic [15:0] scrdat1,
  output logic [1:0]  scrisk0,
  output logic [1:0]  scrisk1
);

  localparam logic [7:0]  SYM_BS = 8'hBC;  // K28.5
  localparam logic [7:0]  SYM_SR = 8'h1C;  // K28.0
  localparam logic [15:0] SEED   = 16'hFFFF;
  localparam logic [15:0] POLY   = 16'h0039; // x^16+x^5+x^4+x^3+1, Galois taps

  // Eight Galois steps: returns the advanced LFSR and the 8-bit key.
  // Key bit k is the feedback bit of step k, so key[0] is used first.
  typedef struct packed {
    logic [15:0] lfsr;
    logic [7:0]  key;
  } adv_t;

  // Result of processing one symbol slot on both lanes.
  typedef struct packed {
    logic [7:0]  sym0;
    logic [7:0]  sym1;
    logic        k0;
    logic        k1;
    logic [15:0] lfsr;
    logic [8:0]  bscnt;
  } slot_t;

  function automatic adv_t lfsr_adv8(input logic [15:0] l_in);
    adv_t        r;
    logic [15:0] l;
    logic        fb;
    l     = l_in;
    r.key = '0;
    for (int k = 0; k < 8; k++) begin
      fb       = l[15];
      r.key[k] = fb;
      l        = {l[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
    r.lfsr = l;
    return r;
  endfunction

  // One slot: substitution decided on lane 0 (lane 1 follows), scramble D
  // symbols with the shared key, then advance/reseed the LFSR.
  function automatic slot_t proc_slot(
    input logic [7:0]  d0,
    input logic [7:0]  d1,
    input logic        k0,
    input logic        k1,
    input logic [15:0] l,
    input logic [8:0]  cnt
  );
    slot_t r;
    adv_t  a;
    logic  bs0;
    logic  bs1;
    logic  sub;
    bs0     = k0 && (d0 == SYM_BS);
    bs1     = k1 && (d1 == SYM_BS);
    sub     = bs0 && (cnt == 9'd0);
    r.k0    = k0;
    r.k1    = k1;
    r.sym0  = sub ? SYM_SR : d0;
    r.sym1  = (sub && bs1) ? SYM_SR : d1;
    // Only BS on lane 0 advances the period counter; input SR does not.
    r.bscnt = cnt + {8'd0, bs0};
    a       = lfsr_adv8(l);
    if (!k0) r.sym0 = r.sym0 ^ a.key;
    if (!k1) r.sym1 = r.sym1 ^ a.key;
    // An SR on lane 0 (substituted or supplied) restarts the sequence for
    // the very next slot, which may be in the same word.
    r.lfsr  = (k0 && (r.sym0 == SYM_SR)) ? SEED : a.lfsr;
    return r;
  endfunction

  logic [15:0] lfsr_q, lfsr_d;
  logic [8:0]  bscnt_q, bscnt_d;
  logic [15:0] scrdat0_q, scrdat0_d;
  logic [15:0] scrdat1_q, scrdat1_d;
  logic [1:0]  scrisk0_q, scrisk0_d;
  logic [1:0]  scrisk1_q, scrisk1_d;
  slot_t       s0;
  slot_t       s1;

  // Next-state: two chained slot evaluations in one cycle, bypassed when disabled.
  always_comb begin
    s0        = proc_slot(dat0[7:0], dat1[7:0], isk0[0], isk1[0], lfsr_q, bscnt_q);
    s1        = proc_slot(dat0[15:8], dat1[15:8], isk0[1], isk1[1], s0.lfsr, s0.bscnt);
    lfsr_d    = SEED;
    bscnt_d   = 9'd0;
    scrdat0_d = dat0;
    scrdat1_d = dat1;
    scrisk0_d = isk0;
    scrisk1_d = isk1;
    if (en) begin
      lfsr_d    = s1.lfsr;
      bscnt_d   = s1.bscnt;
      scrdat0_d = {s1.sym0, s0.sym0};
      scrdat1_d = {s1.sym1, s0.sym1};
      scrisk0_d = {s1.k0, s0.k0};
      scrisk1_d = {s1.k1, s0.k1};
    end
  end

  // State and output registers; reset restarts the sequence and the BS period.
  always_ff @(posedge dpclk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q    <= SEED;
      bscnt_q   <= 9'd0;
      scrdat0_q <= 16'h0000;
      scrdat1_q <= 16'h0000;
      scrisk0_q <= 2'b00;
      scrisk1_q <= 2'b00;
    end else begin
      lfsr_q    <= lfsr_d;
      bscnt_q   <= bscnt_d;
      scrdat0_q <= scrdat0_d;
      scrdat1_q <= scrdat1_d;
      scrisk0_q <= scrisk0_d;
      scrisk1_q <= scrisk1_d;
    end
  end

  assign scrdat0 = scrdat0_q;
  assign scrdat1 = scrdat1_q;
  assign scrisk0 = scrisk0_q;
  assign scrisk1 = scrisk1_q;

endmodule

// File: tb/tb_dp_scrambler.sv
// Self-checking bench for dp_scrambler: constant vector table, hand sequences
// for the multi-cycle corners, and a model-fed scoreboard for long streams.
module tb_dp_scrambler;

  logic        dpclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic [15:0] dat0  = '0;
  logic [15:0] dat1  = '0;
  logic [1:0]  isk0  = '0;
  logic [1:0]  isk1  = '0;
  logic [15:0] scrdat0;
  logic [15:0] scrdat1;
  logic [1:0]  scrisk0;
  logic [1:0]  scrisk1;

  dp_scrambler dut (
    .dpclk   (dpclk),
    .rst_n   (rst_n),
    .en      (en),
    .dat0    (dat0),
    .dat1    (dat1),
    .isk0    (isk0),
    .isk1    (isk1),
    .scrdat0 (scrdat0),
    .scrdat1 (scrdat1),
    .scrisk0 (scrisk0),
    .scrisk1 (scrisk1)
  );

  always #5 dpclk = ~dpclk;

  typedef struct packed {
    logic [15:0] d0;
    logic [1:0]  k0;
    logic [15:0] d1;
    logic [1:0]  k1;
  } word_t;

  typedef struct {
    logic  rst;
    logic  en;
    word_t in;
    word_t ex;
  } vec_t;

  int          n_chk  = 0;
  int          n_pass = 0;
  word_t       sb_q[$];
  logic [15:0] m_l    = 16'hFFFF;
  logic [8:0]  m_cnt  = 9'd0;
  vec_t        tbl[8];
  logic [7:0]  seq[8];

  function automatic word_t mkw(input logic [15:0] d0, input logic [1:0] k0,
                                input logic [15:0] d1, input logic [1:0] k1);
    word_t w;
    w.d0 = d0; w.k0 = k0; w.d1 = d1; w.k1 = k1;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: bit-serial LFSR, symbol by symbol.
  task automatic model_step(input logic e, input word_t in, output word_t ex);
    logic [7:0] b0, b1, key;
    logic       kk0, kk1, fb;
    ex = in;
    if (!e) begin
      m_l   = 16'hFFFF;
      m_cnt = 9'd0;
      return;
    end
    for (int s = 0; s < 2; s++) begin
      b0  = in.d0[s*8 +: 8];
      b1  = in.d1[s*8 +: 8];
      kk0 = in.k0[s];
      kk1 = in.k1[s];
      if (kk0 && b0 == 8'hBC) begin
        if (m_cnt == 9'd0) begin
          b0 = 8'h1C;
          if (kk1 && b1 == 8'hBC) b1 = 8'h1C;
        end
        m_cnt = m_cnt + 9'd1;
      end
      key = 8'h00;
      for (int k = 0; k < 8; k++) begin
        fb     = m_l[15];
        key[k] = fb;
        m_l    = {m_l[14:0], 1'b0} ^ (fb ? 16'h0039 : 16'h0000);
      end
      if (!kk0) b0 = b0 ^ key;
      if (!kk1) b1 = b1 ^ key;
      if (kk0 && b0 == 8'h1C) m_l = 16'hFFFF;
      ex.d0[s*8 +: 8] = b0;
      ex.d1[s*8 +: 8] = b1;
    end
  endtask

  // Called at a negedge: drive, push expectation, sample 1 ns after posedge,
  // pop and compare, return at the following negedge.
  task automatic drive(input logic e, input word_t in, input word_t ex, input string nm);
    word_t got, want;
    en   = e;
    dat0 = in.d0; isk0 = in.k0;
    dat1 = in.d1; isk1 = in.k1;
    sb_q.push_back(ex);
    @(posedge dpclk);
    #1;
    got  = {scrdat0, scrisk0, scrdat1, scrisk1};
    want = sb_q.pop_front();
    chk(nm, got, want);
    @(negedge dpclk);
  endtask

  task automatic model_drive(input logic e, input word_t in, input string nm);
    word_t ex;
    model_step(e, in, ex);
    drive(e, in, ex, nm);
  endtask

  // Called at a negedge (between clock edges): outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; dat0 = '0; dat1 = '0; isk0 = '0; isk1 = '0;
    #1;
    chk("reset_outputs_zero", {scrdat0, scrisk0, scrdat1, scrisk1}, 36'h0);
    m_l   = 16'hFFFF;
    m_cnt = 9'd0;
    @(negedge dpclk);
    rst_n = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic r, input logic e, input word_t in, input word_t ex);
    tbl[i].rst = r; tbl[i].en = e; tbl[i].in = in; tbl[i].ex = ex;
  endtask

  initial begin
    word_t      w, dummy;
    logic [31:0] r, r2;
    logic        want_sr;

    seq[0] = 8'hFF; seq[1] = 8'h17; seq[2] = 8'hC0; seq[3] = 8'h14;
    seq[4] = 8'hB2; seq[5] = 8'hE7; seq[6] = 8'h02; seq[7] = 8'h82;

    // Reset sequence with all-zero D words.
    set_vec(0, 1'b1, 1'b1, mkw(16'h0000, 2'b00, 16'h0000, 2'b00), mkw(16'h17FF, 2'b00, 16'h17FF, 2'b00));
    set_vec(1, 1'b0, 1'b1, mkw(16'h0000, 2'b00, 16'h0000, 2'b00), mkw(16'h14C0, 2'b00, 16'h14C0, 2'b00));
    set_vec(2, 1'b0, 1'b1, mkw(16'h0000, 2'b00, 16'h0000, 2'b00), mkw(16'hE7B2, 2'b00, 16'hE7B2, 2'b00));
    set_vec(3, 1'b0, 1'b1, mkw(16'h0000, 2'b00, 16'h0000, 2'b00), mkw(16'h8202, 2'b00, 16'h8202, 2'b00));
    // First BS after reset becomes SR; slot 1 uses the fresh seed.
    set_vec(4, 1'b1, 1'b1, mkw(16'h00BC, 2'b01, 16'h0000, 2'b00), mkw(16'hFF1C, 2'b01, 16'hFFFF, 2'b00));
    // Disabled: pass-through, BS untouched.
    set_vec(5, 1'b1, 1'b0, mkw(16'hA5BC, 2'b01, 16'h3CBC, 2'b10), mkw(16'hA5BC, 2'b01, 16'h3CBC, 2'b10));
    // Re-enabled: first BS becomes SR on both lanes, sequence restarts.
    set_vec(6, 1'b0, 1'b1, mkw(16'h00BC, 2'b01, 16'h00BC, 2'b01), mkw(16'hFF1C, 2'b01, 16'hFF1C, 2'b01));
    set_vec(7, 1'b0, 1'b1, mkw(16'h0000, 2'b00, 16'h0000, 2'b00), mkw(16'hC017, 2'b00, 16'hC017, 2'b00));

    #2 rst_n = 1'b0;
    @(negedge dpclk);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst) do_reset();
      model_step(tbl[i].en, tbl[i].in, dummy);
      drive(tbl[i].en, tbl[i].in, tbl[i].ex, $sformatf("table_vec%0d", i));
    end

    // Asynchronous reset mid-stream, then the reset sequence again.
    for (int i = 0; i < 5; i++) begin
      r = $urandom();
      model_drive(1'b1, mkw(r[15:0], 2'b00, r[31:16], 2'b00), "pre_reset_stream");
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w = mkw({seq[2*i+1], seq[2*i]}, 2'b00, {seq[2*i+1], seq[2*i]}, 2'b00);
      model_step(1'b1, mkw(16'h0, 2'b00, 16'h0, 2'b00), dummy);
      drive(1'b1, mkw(16'h0, 2'b00, 16'h0, 2'b00), w, $sformatf("midreset_seq%0d", i));
    end

    // 512-BS period over 1025 lane 0 BS, each followed by a D byte.
    do_reset();
    for (int i = 1; i <= 1025; i++) begin
      r = $urandom();
      model_drive(1'b1, mkw(16'h00BC, 2'b01, {r[7:0], 8'hBC}, {1'b0, r[8]}), "bs_period_word");
      want_sr = (i == 1) || (i == 513) || (i == 1025);
      chk($sformatf("bs_period_sr_at_%0d", i), {35'd0, scrdat0[7:0] == 8'h1C}, {35'd0, want_sr});
      if (want_sr) chk("bs_period_byte_after_sr", {28'd0, scrdat0[15:8]}, 36'h0FF);
    end

    // Input SR in slot 1 reseeds but leaves the BS period alone.
    do_reset();
    model_drive(1'b1, mkw(16'h00BC, 2'b01, 16'h0000, 2'b00), "insr_first_bs");
    model_drive(1'b1, mkw(16'h1C00, 2'b10, 16'h0000, 2'b00), "insr_sr_word");
    model_drive(1'b1, mkw(16'h0000, 2'b00, 16'h0000, 2'b00), "insr_next_word");
    chk("insr_next_slot0_key", {28'd0, scrdat0[7:0]}, 36'h0FF);
    for (int j = 2; j <= 513; j++) begin
      model_drive(1'b1, mkw(16'h00BC, 2'b01, 16'h0000, 2'b00), "insr_bs_word");
      if (j == 512) chk("insr_bs512_stays_bs", {28'd0, scrdat0[7:0]}, 36'h0BC);
      if (j == 513) chk("insr_bs513_becomes_sr", {28'd0, scrdat0[7:0]}, 36'h01C);
    end

    // Enable low: pass-through of arbitrary data, then re-enable.
    for (int i = 0; i < 20; i++) begin
      r  = $urandom();
      r2 = $urandom();
      w  = mkw(r[15:0], r2[1:0], r[31:16], r2[3:2]);
      if (r2[4]) begin w.d0[7:0] = 8'hBC; w.k0[0] = 1'b1; end
      model_drive(1'b0, w, "en_off_word");
      chk("en_off_passthrough", {scrdat0, scrisk0, scrdat1, scrisk1}, w);
    end
    model_drive(1'b1, mkw(16'h00BC, 2'b01, 16'h0000, 2'b00), "reenable_word");
    chk("reenable_first_bs_sr", {18'd0, scrdat0, scrisk0}, {18'd0, 16'hFF1C, 2'b01});

    // Mixed stream with enable toggling.
    for (int i = 0; i < 200; i++) begin
      r  = $urandom();
      r2 = $urandom();
      w  = mkw(r[15:0], r2[1:0], r[31:16], r2[3:2]);
      if (r2[4]) begin w.d0[7:0] = 8'hBC; w.k0[0] = 1'b1; end
      if (r2[5]) begin w.d1[15:8] = 8'hBC; w.k1[1] = 1'b1; end
      if (r2[6]) begin w.d0[15:8] = 8'hBC; w.k0[1] = 1'b1; end
      model_drive(r2[15:8] != 8'h00, w, "mixed_stream");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
